// File: rtl/track_sensor_filter_pkg.sv
// Shared types and defaults for the track sensor filter.
// Holds the conflict FSM state encoding and default parameter values.
package track_sensor_filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BOTH  = 2'b01,
        ST_FAULT = 2'b10
    } cflt_state_e;

    localparam int DEBOUNCE_DEF       = 4;
    localparam int CONFLICT_LIMIT_DEF = 16;

endpackage

// File: rtl/track_sensor_filter_if.sv
// Sensor-side bundle: raw contacts in, filtered levels/pulses/fault out.
// master = sensor/supervisor side, slave = the filter block.
interface track_sensor_filter_if;

    logic raw_e;
    logic raw_w;
    logic e_out;
    logic w_out;
    logic e_rise;
    logic w_rise;
    logic conflict;

    modport master (
        output raw_e, raw_w,
        input  e_out, w_out, e_rise, w_rise, conflict
    );

    modport slave (
        input  raw_e, raw_w,
        output e_out, w_out, e_rise, w_rise, conflict
    );

endinterface

// File: rtl/track_sensor_filter_sensor_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce counter, level + rise pulse.
// Ports: clk, rst_n (sync, active-low), raw in; out level, rise one-cycle pulse.
module sensor_debounce
    import track_sensor_filter_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic out,
    output logic rise
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          out_q, out_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d  = raw;
        s2_d  = s1_q;
        out_d = out_q;
        cnt_d = cnt_q;
        if (s2_q == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            out_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // Pulse lands in the same cycle the level first reads 1.
        rise_d = out_d & ~out_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;

endmodule

// File: rtl/track_sensor_filter.sv
// East/west sensor conditioning with a sticky both-active conflict detector.
// Ports: clk, rst_n (sync, active-low), bus (slave): raw_e/raw_w in; filtered out.
module track_sensor_filter
    import track_sensor_filter_pkg::*;
#(
    parameter int DEBOUNCE       = DEBOUNCE_DEF,
    parameter int CONFLICT_LIMIT = CONFLICT_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    track_sensor_filter_if.slave bus
);

    localparam logic [7:0] CLAST = 8'(CONFLICT_LIMIT - 1);

    logic        e_lvl;
    logic        w_lvl;
    logic        both;
    cflt_state_e state_q;
    logic [7:0]  ccnt_q;
    logic        conflict_q;

    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_east (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (bus.raw_e),
        .out  (e_lvl),
        .rise (bus.e_rise)
    );

    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_west (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (bus.raw_w),
        .out  (w_lvl),
        .rise (bus.w_rise)
    );

    assign both = e_lvl & w_lvl;

    // ccnt counts consecutive both-high cycles seen so far in BOTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ccnt_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    conflict_q <= 1'b0;
                    if (both) begin
                        state_q <= ST_BOTH;
                        ccnt_q  <= 8'd1;
                    end
                end
                ST_BOTH: begin
                    if (!both) begin
                        state_q    <= ST_IDLE;
                        ccnt_q     <= '0;
                        conflict_q <= 1'b0;
                    end else if (ccnt_q == CLAST) begin
                        state_q    <= ST_FAULT;
                        conflict_q <= 1'b1;
                    end else begin
                        ccnt_q     <= ccnt_q + 8'd1;
                        conflict_q <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    conflict_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    ccnt_q     <= '0;
                    conflict_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.e_out    = e_lvl;
    assign bus.w_out    = w_lvl;
    assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_track_sensor_filter.sv
// Scoreboard bench for track_sensor_filter: directed + random raw stimulus,
// reference model predicts outputs per edge, monitor compares after each edge.
module tb_track_sensor_filter;

    localparam int D = 4;
    localparam int L = 16;

    logic clk;
    logic rst_n;

    track_sensor_filter_if bus ();

    track_sensor_filter #(
        .DEBOUNCE      (D),
        .CONFLICT_LIMIT(L)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector: {e_out, w_out, e_rise, w_rise, conflict}
    logic [4:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;
    bit saw_conflict = 0;

    // Reference model state
    bit e_raw_h[$], w_raw_h[$];
    bit e_seen[$],  w_seen[$];
    bit m_e, m_w, m_er, m_wr, m_cf;
    int run;

    // Level flips once the last d synchronised samples all disagree with it.
    function automatic bit follow(input bit q[$], input bit cur, input int d);
        int n;
        n = q.size();
        if (n < d) return cur;
        for (int i = n - d; i < n; i++)
            if (q[i] == cur) return cur;
        return !cur;
    endfunction

    // Synchronised sample seen now = raw captured two edges ago (0 across reset).
    function automatic bit delayed2(input bit q[$]);
        if (q.size() < 2) return 1'b0;
        return q[q.size()-2];
    endfunction

    always @(posedge clk) begin
        bit ne, nw, both_pre;
        if (rst_n === 1'b0) begin
            started = 1;
            e_raw_h.delete(); w_raw_h.delete();
            e_seen.delete();  w_seen.delete();
            {m_e, m_w, m_er, m_wr, m_cf} = '0;
            run = 0;
            exp_q.push_back(5'b0);
        end else if (started) begin
            both_pre = m_e & m_w;
            e_seen.push_back(delayed2(e_raw_h));
            w_seen.push_back(delayed2(w_raw_h));
            e_raw_h.push_back(bus.raw_e);
            w_raw_h.push_back(bus.raw_w);
            ne = follow(e_seen, m_e, D);
            nw = follow(w_seen, m_w, D);
            m_er = ne & !m_e;
            m_wr = nw & !m_w;
            m_e = ne;
            m_w = nw;
            run = both_pre ? run + 1 : 0;
            if (run >= L) m_cf = 1;
            exp_q.push_back({m_e, m_w, m_er, m_wr, m_cf});
        end
    end

    always @(posedge clk) begin
        logic [4:0] ex, act;
        #1;
        if (exp_q.size() > 0) begin
            ex  = exp_q.pop_front();
            act = {bus.e_out, bus.w_out, bus.e_rise, bus.w_rise, bus.conflict};
            if (bus.conflict === 1'b1) saw_conflict = 1;
            n_checks++;
            if (act !== ex) begin
                n_fail++;
                $display("FAIL outputs t=%0t got {e,w,er,wr,cf}=%b expected %b",
                         $time, act, ex);
            end
        end else if (started) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty t=%0t no expected entry", $time);
        end
    end

    task automatic drive(input bit re, input bit rw, input bit rst, input int n);
        bus.raw_e = re;
        bus.raw_w = rw;
        rst_n     = rst;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.raw_e = 1'b1;
        bus.raw_w = 1'b1;
        rst_n     = 1'b0;
        // 1: reset with raw high, then release
        drive(1, 1, 0, 3);
        drive(1, 1, 1, 10);
        drive(0, 0, 1, 10);
        // 2: short and exact-width west pulses
        drive(0, 1, 1, 3);
        drive(0, 0, 1, 10);
        drive(0, 1, 1, 4);
        drive(0, 0, 1, 12);
        // 3: east fall, then fall interrupted by a blip
        drive(1, 0, 1, 8);
        drive(0, 0, 1, 10);
        drive(1, 0, 1, 8);
        drive(0, 0, 1, 2);
        drive(1, 0, 1, 1);
        drive(0, 0, 1, 12);
        // 4: 15 both-high cycles, then 16
        drive(1, 1, 1, 15);
        drive(1, 0, 1, 12);
        drive(0, 0, 1, 10);
        drive(1, 1, 1, 16);
        drive(0, 0, 1, 12);
        // 5: single reset edge while in FAULT
        drive(0, 0, 0, 1);
        drive(0, 0, 1, 10);
        // 6: 1-cycle alternation on east
        for (int i = 0; i < 50; i++) drive(bit'(i & 1), 0, 1, 1);
        drive(0, 0, 1, 10);
        // Random segments with occasional reset
        for (int i = 0; i < 120; i++) begin
            bit re, rw, rs;
            re = bit'($urandom_range(0, 1));
            rw = bit'($urandom_range(0, 1));
            rs = ($urandom_range(0, 19) != 0);
            drive(re, rw, rs, rs ? $urandom_range(1, 24) : 1);
        end
        drive(0, 0, 1, 5);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        n_checks++;
        if (!saw_conflict) begin
            n_fail++;
            $display("FAIL conflict_seen got 0 expected 1");
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
